// File: rtl/hazard3_irq_gateway_mt_if.sv
// hazard3_irq_gateway_mt_if: config bus plus claim/complete handshake between targets and the interrupt controller
interface hazard3_irq_gateway_mt_if #(
  parameter int NUM_TARGETS = 2
);
  logic cfg_wen;
  logic [9:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic [NUM_TARGETS-1:0] claim_req;
  logic [NUM_TARGETS-1:0] claim_ack;
  logic [6:0] claim_id;
  logic claim_none;
  logic [NUM_TARGETS-1:0] complete_req;
  logic [7*NUM_TARGETS-1:0] complete_id;
  logic [NUM_TARGETS-1:0] irq_pending;
  modport master (
    output cfg_wen, cfg_addr, cfg_wdata, claim_req, complete_req, complete_id,
    input  cfg_rdata, claim_ack, claim_id, claim_none, irq_pending
  );
  modport slave (
    input  cfg_wen, cfg_addr, cfg_wdata, claim_req, complete_req, complete_id,
    output cfg_rdata, claim_ack, claim_id, claim_none, irq_pending
  );
endinterface

// File: rtl/hazard3_irq_gateway_mt.sv
// hazard3_irq_gateway_mt: per-IRQ gateways with edge latch, per-target priority arbiter, claim/complete handshake
module hazard3_irq_gateway_mt #(
  parameter int NUM_IRQS = 32,
  parameter int NUM_TARGETS = 2,
  parameter int IRQ_PRIORITY_BITS = 4,
  parameter int W_DATA = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_IRQS-1:0] irq,
  hazard3_irq_gateway_mt_if.slave bus
);
  localparam int PB = IRQ_PRIORITY_BITS;
  localparam int TW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1;
  typedef enum logic [1:0] {IDLE, PENDING, CLAIMED} gw_state_t;
  gw_state_t r_state [NUM_IRQS];
  gw_state_t w_state_nxt [NUM_IRQS];
  logic [TW-1:0] r_claimer [NUM_IRQS];
  logic [PB-1:0] r_prio [NUM_IRQS];
  logic [NUM_IRQS-1:0] r_irq_s, r_irq_s_d, r_latch, r_trig;
  logic [NUM_IRQS-1:0] w_latch_nxt, w_rise, w_pend, w_cmp, w_tw;
  logic [NUM_IRQS-1:0] r_en [NUM_TARGETS];
  logic [PB-1:0] r_thresh [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] r_ack, r_irq_pending, w_found;
  logic [PB-1:0] w_best [NUM_TARGETS];
  logic [6:0] w_win [NUM_TARGETS];
  logic [6:0] r_id, w_gid;
  logic r_none, w_any, w_grant;
  logic [TW-1:0] w_sel;
  logic [PB-1:0] w_prio_pad [128];
  logic [127:0] w_en_pad [16];
  logic [PB-1:0] w_thr_pad [16];
  logic [127:0] w_trig_pad, w_pend_pad;
  logic [W_DATA-1:0] w_rdata;
  assign w_rise = r_irq_s & ~r_irq_s_d;
  always_comb
    for (int i = 0; i < NUM_IRQS; i++) w_pend[i] = r_state[i] == PENDING;
  // Seeding best with the threshold makes "prio > threshold" and priority 0 fall out of one compare
  always_comb
    for (int t = 0; t < NUM_TARGETS; t++) begin
      w_best[t] = r_thresh[t];
      w_found[t] = 1'b0;
      w_win[t] = '0;
      for (int i = 0; i < NUM_IRQS; i++)
        if (w_pend[i] && r_en[t][i] && r_prio[i] > w_best[t]) begin
          w_best[t] = r_prio[i];
          w_found[t] = 1'b1;
          w_win[t] = 7'(i);
        end
    end
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int t = NUM_TARGETS - 1; t >= 0; t--)
      if (bus.claim_req[t] && !r_ack[t]) begin
        w_sel = TW'(t);
        w_any = 1'b1;
      end
    w_grant = w_any && w_found[w_sel];
    w_gid = w_win[w_sel];
    w_cmp = '0;
    w_tw = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      for (int t = 0; t < NUM_TARGETS; t++)
        if (bus.complete_req[t] && bus.complete_id[7*t +: 7] == 7'(i) && r_claimer[i] == TW'(t))
          w_cmp[i] = 1'b1;
      w_tw[i] = bus.cfg_wen && bus.cfg_addr == 10'('h80 + i / 32);
      w_state_nxt[i] = r_state[i];
      if (r_state[i] == IDLE && (r_trig[i] ? w_rise[i] : r_irq_s[i]))
        w_state_nxt[i] = PENDING;
      if (r_state[i] == PENDING && w_grant && w_gid == 7'(i))
        w_state_nxt[i] = CLAIMED;
      // An edge landing with the complete counts as latched, so the IRQ re-pends
      if (r_state[i] == CLAIMED && w_cmp[i])
        w_state_nxt[i] = (r_latch[i] || (r_trig[i] && w_rise[i])) ? PENDING : IDLE;
      w_latch_nxt[i] = ((r_state[i] == CLAIMED && w_cmp[i]) || w_tw[i]) ? 1'b0 :
                       (r_latch[i] || (r_trig[i] && w_rise[i] && r_state[i] != IDLE));
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_irq_s <= '0;
      r_irq_s_d <= '0;
      r_latch <= '0;
      r_trig <= '0;
      r_ack <= '0;
      r_irq_pending <= '0;
      r_id <= '0;
      r_none <= 1'b0;
      for (int i = 0; i < NUM_IRQS; i++) begin
        r_state[i] <= IDLE;
        r_claimer[i] <= '0;
        r_prio[i] <= '0;
      end
      for (int t = 0; t < NUM_TARGETS; t++) begin
        r_en[t] <= '0;
        r_thresh[t] <= '0;
      end
    end else begin
      r_irq_s <= irq;
      r_irq_s_d <= r_irq_s;
      r_latch <= w_latch_nxt;
      r_ack <= w_any ? NUM_TARGETS'(1) << w_sel : '0;
      r_id <= w_grant ? w_gid : '0;
      r_none <= w_any && !w_grant;
      r_irq_pending <= w_found;
      for (int i = 0; i < NUM_IRQS; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_grant && w_gid == 7'(i)) r_claimer[i] <= w_sel;
        if (bus.cfg_wen && bus.cfg_addr == 10'(i)) r_prio[i] <= bus.cfg_wdata[PB-1:0];
        if (w_tw[i]) r_trig[i] <= bus.cfg_wdata[i % 32];
        for (int t = 0; t < NUM_TARGETS; t++)
          if (bus.cfg_wen && bus.cfg_addr == 10'('h100 + 16 * t + i / 32))
            r_en[t][i] <= bus.cfg_wdata[i % 32];
      end
      for (int t = 0; t < NUM_TARGETS; t++)
        if (bus.cfg_wen && bus.cfg_addr == 10'('h200 + t)) r_thresh[t] <= bus.cfg_wdata[PB-1:0];
    end
  // Zero-padded views let the full address fields index directly; missing entries read 0
  always_comb begin
    w_prio_pad = '{default: '0};
    w_en_pad = '{default: '0};
    w_thr_pad = '{default: '0};
    for (int i = 0; i < NUM_IRQS; i++) w_prio_pad[i] = r_prio[i];
    for (int t = 0; t < NUM_TARGETS; t++) begin
      w_en_pad[t] = 128'(r_en[t]);
      w_thr_pad[t] = r_thresh[t];
    end
    w_trig_pad = 128'(r_trig);
    w_pend_pad = 128'(w_pend);
    w_rdata = '0;
    if (bus.cfg_addr[9:7] == 3'b000)
      w_rdata = W_DATA'(w_prio_pad[bus.cfg_addr[6:0]]);
    else if (bus.cfg_addr[9:4] == 6'h08 && bus.cfg_addr[3:2] == 2'b00)
      w_rdata = w_trig_pad[{bus.cfg_addr[1:0], 5'd0} +: 32];
    else if (bus.cfg_addr[9:4] == 6'h09 && bus.cfg_addr[3:2] == 2'b00)
      w_rdata = w_pend_pad[{bus.cfg_addr[1:0], 5'd0} +: 32];
    else if (bus.cfg_addr[9:8] == 2'b01 && bus.cfg_addr[3:2] == 2'b00)
      w_rdata = w_en_pad[bus.cfg_addr[7:4]][{bus.cfg_addr[1:0], 5'd0} +: 32];
    else if (bus.cfg_addr[9:4] == 6'h20)
      w_rdata = W_DATA'(w_thr_pad[bus.cfg_addr[3:0]]);
  end
  assign bus.cfg_rdata = w_rdata;
  assign bus.claim_ack = r_ack;
  assign bus.claim_id = r_id;
  assign bus.claim_none = r_none;
  assign bus.irq_pending = r_irq_pending;
endmodule

// File: tb/tb_hazard3_irq_gateway_mt.sv
// tb_hazard3_irq_gateway_mt: directed vectors for gateway, arbitration, claim/complete and config map
module tb_hazard3_irq_gateway_mt;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] irq;
  int n_chk = 0;
  int n_err = 0;
  hazard3_irq_gateway_mt_if #(.NUM_TARGETS(2)) bus ();
  hazard3_irq_gateway_mt dut (.clk(clk), .rst(rst), .irq(irq), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    bus.cfg_wen = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_wen = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    bus.cfg_addr = a;
    #1;
    chk(tag, bus.cfg_rdata, exp);
  endtask
  task automatic claim(input int t, input logic [6:0] eid, input logic enone, input string tag);
    logic got = 1'b0;
    bus.claim_req[t] = 1'b1;
    for (int n = 0; n < 4 && !got; n++) begin
      tick();
      if (bus.claim_ack[t]) begin
        got = 1'b1;
        chk({tag, "_id"}, bus.claim_id, eid);
        chk({tag, "_none"}, bus.claim_none, enone);
      end
    end
    bus.claim_req[t] = 1'b0;
    chk({tag, "_ack"}, got, 1);
  endtask
  task automatic complete(input int t, input logic [6:0] id);
    bus.complete_req[t] = 1'b1;
    bus.complete_id[7*t +: 7] = id;
    tick();
    bus.complete_req[t] = 1'b0;
  endtask
  task automatic pulse(input int n);
    irq[n] = 1'b1;
    tick();
    irq[n] = 1'b0;
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    irq = '0;
    bus.cfg_wen = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.claim_req = '0;
    bus.complete_req = '0;
    bus.complete_id = '0;
    tick(2);
    chk("rst_ack", bus.claim_ack, 0);
    chk("rst_pend", bus.irq_pending, 0);
    chk("rst_id", bus.claim_id, 0);
    chk("rst_none", bus.claim_none, 0);
    rst = 1'b0;
    tick();
    // level-triggered IRQ 3
    wr(3, 2);
    wr('h100, 'h8);
    wr('h200, 0);
    irq[3] = 1'b1;
    tick(2);
    chk("lvl_pend_early", bus.irq_pending, 0);
    tick();
    chk("lvl_pend", bus.irq_pending, 1);
    rd_chk("lvl_pendreg", 'h090, 'h8);
    claim(0, 3, 0, "lvl_claim");
    rd_chk("lvl_claimed", 'h090, 0);
    complete(0, 3);
    tick();
    rd_chk("lvl_repend", 'h090, 'h8);
    irq[3] = 1'b0;
    claim(0, 3, 0, "lvl_claim2");
    complete(0, 3);
    tick(2);
    rd_chk("lvl_idle", 'h090, 0);
    chk("lvl_pend_clr", bus.irq_pending, 0);
    wr('h100, 0);
    // edge-triggered IRQ 5 with coalescing
    wr('h080, 'h20);
    wr(5, 1);
    wr('h100, 'h20);
    pulse(5);
    tick(2);
    claim(0, 5, 0, "edge_claim1");
    repeat (3) pulse(5);
    tick(2);
    rd_chk("edge_claimed", 'h090, 0);
    complete(0, 5);
    rd_chk("edge_repend", 'h090, 'h20);
    claim(0, 5, 0, "edge_claim2");
    claim(0, 0, 1, "edge_claim3");
    complete(0, 5);
    tick();
    rd_chk("edge_idle", 'h090, 0);
    wr('h100, 0);
    // arbitration and threshold
    wr(1, 3);
    wr(7, 3);
    wr(9, 5);
    wr('h100, 'h282);
    irq[1] = 1'b1;
    irq[7] = 1'b1;
    irq[9] = 1'b1;
    tick(3);
    claim(0, 9, 0, "arb_a");
    claim(0, 1, 0, "arb_b");
    claim(0, 7, 0, "arb_c");
    claim(0, 0, 1, "arb_empty");
    complete(0, 9);
    complete(0, 1);
    complete(0, 7);
    wr('h200, 3);
    tick(2);
    claim(0, 9, 0, "thr_a");
    claim(0, 0, 1, "thr_none");
    irq[1] = 1'b0;
    irq[7] = 1'b0;
    irq[9] = 1'b0;
    tick(2);
    complete(0, 9);
    wr('h200, 0);
    claim(0, 1, 0, "thr_b");
    claim(0, 7, 0, "thr_c");
    complete(0, 1);
    complete(0, 7);
    tick();
    rd_chk("arb_idle", 'h090, 0);
    wr('h100, 0);
    // two targets contend for IRQ 4
    wr(4, 1);
    wr('h100, 'h10);
    wr('h110, 'h10);
    irq[4] = 1'b1;
    tick(3);
    bus.claim_req = 2'b11;
    tick();
    chk("mt_ack0", bus.claim_ack, 2'b01);
    chk("mt_id0", bus.claim_id, 4);
    chk("mt_none0", bus.claim_none, 0);
    bus.claim_req[0] = 1'b0;
    tick();
    chk("mt_ack1", bus.claim_ack, 2'b10);
    chk("mt_none1", bus.claim_none, 1);
    chk("mt_id1", bus.claim_id, 0);
    bus.claim_req[1] = 1'b0;
    complete(1, 4);
    tick(2);
    rd_chk("mt_wrong_cmp", 'h090, 0);
    complete(0, 4);
    tick();
    rd_chk("mt_right_cmp", 'h090, 'h10);
    // reset lands on the edge where the ack would rise
    bus.claim_req[0] = 1'b1;
    #4;
    rst = 1'b1;
    tick();
    chk("rmh_ack", bus.claim_ack, 0);
    chk("rmh_none", bus.claim_none, 0);
    chk("rmh_id", bus.claim_id, 0);
    chk("rmh_pend", bus.irq_pending, 0);
    rd_chk("rmh_prio", 4, 0);
    rd_chk("rmh_en", 'h100, 0);
    rd_chk("rmh_pendreg", 'h090, 0);
    bus.claim_req[0] = 1'b0;
    rst = 1'b0;
    wr(4, 1);
    wr('h100, 'h10);
    tick(2);
    chk("rmh_repend", bus.irq_pending, 1);
    rd_chk("rmh_pendreg2", 'h090, 'h10);
    // config map
    wr(0, 'hFF);
    rd_chk("cfg_prio_mask", 0, 'h0F);
    wr('h3FF, 'hFFFFFFFF);
    rd_chk("cfg_unimpl", 'h3FF, 0);
    wr('h020, 'hF);
    rd_chk("cfg_prio_oob", 'h020, 0);
    wr('h201, 'hFF);
    rd_chk("cfg_thr1", 'h201, 'hF);
    wr('h080, 'hFFFFFFFF);
    rd_chk("cfg_trig", 'h080, 'hFFFFFFFF);
    rd_chk("cfg_trig_w1", 'h081, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard3_irq_gateway_mt.md
Name: hazard3_irq_gateway_mt

Overview:
Multi-target external interrupt controller with claim/complete semantics.
- Each IRQ input passes through a per-IRQ gateway: input sync flop, level or edge trigger, and a one-deep edge latch.
- A per-target priority arbiter selects the best pending IRQ for each target.
- Sits between SoC interrupt sources and up to 16 hart or debug targets, each of which claims and completes IRQs over a simple request/acknowledge port.

Parameters:
NUM_IRQS, 32, number of IRQ inputs (1..128)
NUM_TARGETS, 2, number of claim targets (1..16)
IRQ_PRIORITY_BITS, 4, implemented priority width (1..8)
W_DATA, 32, config data width (fixed at 32)

Ports:
clk  input  1  sole clock
rst  input  1  asynchronous active-high reset
irq  input  NUM_IRQS  raw interrupt lines (asynchronous to clk)
cfg_wen  input  1  config write strobe
cfg_addr  input  10  config word address
cfg_wdata  input  32  config write data
cfg_rdata  output  32  config read data (combinational on cfg_addr)
claim_req  input  NUM_TARGETS  per-target claim request, level, held until ack
claim_ack  output  NUM_TARGETS  one-cycle claim acknowledge
claim_id  output  7  IRQ index granted; valid only with claim_ack
claim_none  output  1  with claim_ack: no eligible IRQ, claim_id=0
complete_req  input  NUM_TARGETS  per-target complete pulse
complete_id  input  7*NUM_TARGETS  IRQ index being completed, per target
irq_pending  output  NUM_TARGETS  registered: target has an eligible IRQ

Behaviour:
Reset:
- Asserting rst clears all state immediately, including mid-handshake.
- All gateways go to IDLE; edge latches, sync flops, priorities, trigger bits, enables and thresholds clear to 0.
- claim_ack, claim_none, claim_id and irq_pending are 0.

Register map (word addresses):
- 0x000+i PRIORITY[i]: bits [IRQ_PRIORITY_BITS-1:0], RW.
- 0x080+k TRIGGER word k: bit=1 edge, 0 level; RW.
- 0x090+k PENDING word k: RO, bit=1 when gateway is PENDING.
- 0x100+16t+k ENABLE target t, word k: RW.
- 0x200+t THRESHOLD[t]: bits [IRQ_PRIORITY_BITS-1:0], RW.
- Unimplemented addresses and bits read 0; writes to them are ignored.
- All writes take effect the following cycle.

Input path:
- irq is registered once into irq_s.
- Edge detect is rising edge of irq_s versus its previous value (irq_s_d).

Gateway FSM (per IRQ):
- IDLE -> PENDING: level mode with irq_s=1, or edge mode with a rising edge.
- PENDING -> CLAIMED: when granted to some target; the claimer index is stored.
- CLAIMED -> IDLE: on complete_req from the stored claimer with matching complete_id.
- Complete with a mismatched target, an id not in CLAIMED, or id>=NUM_IRQS is ignored.
- Level mode still high at complete: gateway re-enters PENDING on the next cycle, via IDLE.
- Edge arriving while PENDING or CLAIMED sets the edge latch (one deep; further edges are lost).
- Latch set at complete: gateway goes to PENDING instead of IDLE and the latch clears.
- Writing a TRIGGER bit clears that IRQ's edge latch; gateway state is unchanged.

Eligibility and arbitration:
- IRQ i is eligible for target t when PENDING, ENABLE[t][i]=1, and PRIORITY[i] > THRESHOLD[t].
- Priority 0 is never eligible.
- Winner is highest priority; ties go to the lowest index.
- irq_pending[t] is registered: it reflects eligibility as of the previous cycle's state.

Claim handshake:
- At most one claim is granted per cycle.
- Among requesting targets with claim_ack low, the lowest index wins.
- The ack is registered, so it rises at minimum 1 cycle after req is sampled.
- In the ack cycle, claim_id and claim_none are valid and the gateway is already CLAIMED.
- The target drops req the cycle after ack. A req still high in the cycle after ack is a new claim.
- A claim finding no eligible IRQ acks with claim_none=1.

Simultaneous events:
- Complete and claim in the same cycle: complete applies first, so a re-pended IRQ is claimable from the next cycle.
- A complete from target t for IRQ i and a rising edge on irq[i] in the same cycle set the edge latch before the complete is evaluated, so the IRQ re-pends.

Test Plan:
- Level IRQ: PRIORITY[3]=2, ENABLE[0]=0x8, THRESHOLD[0]=0, irq[3]=1 -> irq_pending[0]=1 three cycles later; claim -> ack with id=3. Complete id=3 while irq[3] still 1 -> PENDING bit 3 set again within 2 cycles.
- Edge coalescing: TRIGGER bit5=1, PRIORITY[5]=1, three pulses on irq[5] while CLAIMED -> after complete exactly one re-pend; second claim returns 5, third claim returns claim_none.
- Arbitration: PRIORITY[1]=3, PRIORITY[7]=3, PRIORITY[9]=5, all pending and enabled -> claims return 9, then 1, then 7. With THRESHOLD[0]=3 -> only 9 is claimable.
- Multi-target contention: targets 0 and 1 request in the same cycle, single IRQ 4 pending -> target 0 acks id=4, target 1 acks next cycle with claim_none=1. Complete of 4 from target 1 is ignored; PENDING stays 0 and the gateway remains CLAIMED.
- Reset mid-handshake: assert rst in the cycle claim_ack would rise -> ack stays 0, all outputs 0, registers read 0; after release, level irq still high re-pends.
- Config readback: write 0xFF to PRIORITY[0] with IRQ_PRIORITY_BITS=4 -> reads 0x0F; write to 0x3FF -> no effect, reads 0.
